// File: rtl/pzcorebus_downsizer_response_packer.sv
// Packs narrow read-response beats into wide beats. Each command's first beat
// lands in the lane that the start-lane FIFO gives for it.
module pzcorebus_downsizer_response_packer #(
    parameter int unsigned NARROW_DATA_WIDTH = 64,
    parameter int unsigned CONVERSION_RATIO  = 2,
    parameter int unsigned INFO_DEPTH        = 4,
    parameter int unsigned ID_WIDTH          = 8,
    localparam int unsigned LANE_WIDTH       = $clog2(CONVERSION_RATIO),
    localparam int unsigned WIDE_DATA_WIDTH  = NARROW_DATA_WIDTH * CONVERSION_RATIO
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_info_valid,
    output logic                         o_info_ready,
    input  logic [LANE_WIDTH-1:0]        i_info_lane,
    input  logic                         i_nresp_valid,
    output logic                         o_nresp_accept,
    input  logic                         i_nresp_with_data,
    input  logic [ID_WIDTH-1:0]          i_nresp_id,
    input  logic                         i_nresp_error,
    input  logic [NARROW_DATA_WIDTH-1:0] i_nresp_data,
    input  logic                         i_nresp_last,
    output logic                         o_wresp_valid,
    input  logic                         i_wresp_accept,
    output logic                         o_wresp_with_data,
    output logic [ID_WIDTH-1:0]          o_wresp_id,
    output logic                         o_wresp_error,
    output logic [WIDE_DATA_WIDTH-1:0]   o_wresp_data,
    output logic                         o_wresp_last
);

    localparam int unsigned PTR_WIDTH = (INFO_DEPTH > 1) ? $clog2(INFO_DEPTH) : 1;
    localparam int unsigned CNT_WIDTH = $clog2(INFO_DEPTH + 1);
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(CONVERSION_RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_e;

    state_e                        state_q;
    logic [LANE_WIDTH-1:0]         lane_q;
    logic [WIDE_DATA_WIDTH-1:0]    acc_data_q;
    logic                          acc_error_q;

    logic [LANE_WIDTH-1:0]         info_mem_q [INFO_DEPTH];
    logic [PTR_WIDTH-1:0]          wr_ptr_q;
    logic [PTR_WIDTH-1:0]          rd_ptr_q;
    logic [CNT_WIDTH-1:0]          count_q;
    logic [CNT_WIDTH-1:0]          count_d;
    logic                          info_ready_q;

    logic                          wresp_valid_q;
    logic                          wresp_with_data_q;
    logic [ID_WIDTH-1:0]           wresp_id_q;
    logic                          wresp_error_q;
    logic [WIDE_DATA_WIDTH-1:0]    wresp_data_q;
    logic                          wresp_last_q;

    logic                          fifo_empty_c;
    logic                          push_c;
    logic                          pop_c;
    logic [LANE_WIDTH-1:0]         cur_lane_c;
    logic                          completing_c;
    logic                          out_free_c;
    logic                          nresp_accept_c;
    logic                          data_fire_c;
    logic                          nodata_fire_c;
    logic                          load_out_c;
    logic [WIDE_DATA_WIDTH-1:0]    beat_vec_c;
    logic [WIDE_DATA_WIDTH-1:0]    wide_data_c;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(INFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign fifo_empty_c = (count_q == '0);
    assign push_c       = i_info_valid && info_ready_q;
    assign pop_c        = data_fire_c && i_nresp_last;

    // The first beat of a response takes its lane from the FIFO head.
    assign cur_lane_c   = (state_q == IDLE) ? info_mem_q[rd_ptr_q] : lane_q;
    assign completing_c = (cur_lane_c == LAST_LANE) || i_nresp_last;
    assign out_free_c   = !wresp_valid_q || i_wresp_accept;

    // Only beats that load the output register need it to be free.
    always_comb begin
        nresp_accept_c = 1'b0;
        if (!i_nresp_with_data) begin
            nresp_accept_c = (state_q == IDLE) && out_free_c;
        end else if ((state_q == IDLE) && fifo_empty_c) begin
            nresp_accept_c = 1'b0;
        end else if (completing_c) begin
            nresp_accept_c = out_free_c;
        end else begin
            nresp_accept_c = 1'b1;
        end
    end

    assign data_fire_c   = i_nresp_valid && nresp_accept_c && i_nresp_with_data;
    assign nodata_fire_c = i_nresp_valid && nresp_accept_c && !i_nresp_with_data;
    assign load_out_c    = (data_fire_c && completing_c) || nodata_fire_c;

    // Current narrow beat placed in its lane, other lanes zero.
    always_comb begin
        beat_vec_c = '0;
        for (int unsigned i = 0; i < CONVERSION_RATIO; i++) begin
            if (cur_lane_c == LANE_WIDTH'(i)) begin
                beat_vec_c[i*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH] = i_nresp_data;
            end
        end
    end

    assign wide_data_c = acc_data_q | beat_vec_c;

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Lane storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            info_mem_q[wr_ptr_q] <= i_info_lane;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= IDLE;
            lane_q            <= '0;
            acc_data_q        <= '0;
            acc_error_q       <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            info_ready_q      <= 1'b1;
            wresp_valid_q     <= 1'b0;
            wresp_with_data_q <= 1'b0;
            wresp_id_q        <= '0;
            wresp_error_q     <= 1'b0;
            wresp_data_q      <= '0;
            wresp_last_q      <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q      <= count_d;
            info_ready_q <= (count_d != CNT_WIDTH'(INFO_DEPTH));

            if (data_fire_c) begin
                lane_q  <= cur_lane_c + LANE_WIDTH'(1);
                state_q <= i_nresp_last ? IDLE : PACK;
                if (completing_c) begin
                    acc_data_q  <= '0;
                    acc_error_q <= 1'b0;
                end else begin
                    acc_data_q  <= wide_data_c;
                    acc_error_q <= acc_error_q | i_nresp_error;
                end
            end

            // Output register loads on a completing or no-data beat, else drains.
            if (load_out_c) begin
                wresp_valid_q     <= 1'b1;
                wresp_with_data_q <= i_nresp_with_data;
                wresp_id_q        <= i_nresp_id;
                wresp_last_q      <= i_nresp_last;
                if (i_nresp_with_data) begin
                    wresp_data_q  <= wide_data_c;
                    wresp_error_q <= acc_error_q | i_nresp_error;
                end else begin
                    wresp_data_q  <= '0;
                    wresp_error_q <= i_nresp_error;
                end
            end else if (i_wresp_accept) begin
                wresp_valid_q <= 1'b0;
            end
        end
    end

    assign o_info_ready      = info_ready_q;
    assign o_nresp_accept    = nresp_accept_c;
    assign o_wresp_valid     = wresp_valid_q;
    assign o_wresp_with_data = wresp_with_data_q;
    assign o_wresp_id        = wresp_id_q;
    assign o_wresp_error     = wresp_error_q;
    assign o_wresp_data      = wresp_data_q;
    assign o_wresp_last      = wresp_last_q;

endmodule

// File: tb/tb_pzcorebus_downsizer_response_packer.sv
// Self-checking bench for the response packer: directed scenarios followed by
// randomized bursts, compared against a lane-position model of wide beats.
module tb_pzcorebus_downsizer_response_packer;

    localparam int NW    = 64;
    localparam int R     = 2;
    localparam int DEPTH = 4;
    localparam int IDW   = 8;
    localparam int WW    = NW * R;
    localparam int CW    = 160;

    logic           clk;
    logic           rst_n;
    logic           i_info_valid;
    logic           o_info_ready;
    logic [0:0]     i_info_lane;
    logic           i_nresp_valid;
    logic           o_nresp_accept;
    logic           i_nresp_with_data;
    logic [IDW-1:0] i_nresp_id;
    logic           i_nresp_error;
    logic [NW-1:0]  i_nresp_data;
    logic           i_nresp_last;
    logic           o_wresp_valid;
    logic           i_wresp_accept;
    logic           o_wresp_with_data;
    logic [IDW-1:0] o_wresp_id;
    logic           o_wresp_error;
    logic [WW-1:0]  o_wresp_data;
    logic           o_wresp_last;

    pzcorebus_downsizer_response_packer #(
        .NARROW_DATA_WIDTH (NW),
        .CONVERSION_RATIO  (R),
        .INFO_DEPTH        (DEPTH),
        .ID_WIDTH          (IDW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_info_valid      (i_info_valid),
        .o_info_ready      (o_info_ready),
        .i_info_lane       (i_info_lane),
        .i_nresp_valid     (i_nresp_valid),
        .o_nresp_accept    (o_nresp_accept),
        .i_nresp_with_data (i_nresp_with_data),
        .i_nresp_id        (i_nresp_id),
        .i_nresp_error     (i_nresp_error),
        .i_nresp_data      (i_nresp_data),
        .i_nresp_last      (i_nresp_last),
        .o_wresp_valid     (o_wresp_valid),
        .i_wresp_accept    (i_wresp_accept),
        .o_wresp_with_data (o_wresp_with_data),
        .o_wresp_id        (o_wresp_id),
        .o_wresp_error     (o_wresp_error),
        .o_wresp_data      (o_wresp_data),
        .o_wresp_last      (o_wresp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0]  data;
        logic [IDW-1:0] id;
        logic           err;
        logic           last;
        logic           wd;
    } exp_t;

    exp_t           exp_q[$];
    int             info_q[$];
    int             checks   = 0;
    int             failures = 0;
    bit             hold_prev;
    logic [CW-1:0]  saved;
    bit             last_nacc;
    bit             rnd_acc;

    logic [NW-1:0]  gd[16];
    logic           ge[16];
    logic [IDW-1:0] gi[16];
    int             gn;
    int             gstart;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CW-1:0] out_vec();
        return CW'({o_wresp_valid, o_wresp_with_data, o_wresp_error, o_wresp_last,
                    o_wresp_id, o_wresp_data});
    endfunction

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (hold_prev) chk("hold_stable", out_vec(), saved);
        if (o_wresp_valid && i_wresp_accept) begin
            chk("wresp_expected_pending", CW'(exp_q.size() != 0), CW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wresp_data", CW'(o_wresp_data), CW'(e.data));
                chk("wresp_id", CW'(o_wresp_id), CW'(e.id));
                chk("wresp_flags", CW'({o_wresp_with_data, o_wresp_error, o_wresp_last}),
                    CW'({e.wd, e.err, e.last}));
            end
        end
        hold_prev = o_wresp_valid && !i_wresp_accept;
        saved     = out_vec();
        last_nacc = i_nresp_valid && o_nresp_accept;
        @(posedge clk);
        #1;
        if (rnd_acc) i_wresp_accept = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_info(input int lane);
        chk("info_ready", CW'(o_info_ready), CW'(info_q.size() < DEPTH));
        i_info_valid = 1'b1;
        i_info_lane  = 1'(lane);
        cycle();
        i_info_valid = 1'b0;
        if (info_q.size() < DEPTH) info_q.push_back(lane);
    endtask

    task automatic send_beat(input logic [NW-1:0] d, input logic err, input logic [IDW-1:0] id,
                             input logic last, input logic wd, output bit acc);
        i_nresp_valid     = 1'b1;
        i_nresp_data      = d;
        i_nresp_error     = err;
        i_nresp_id        = id;
        i_nresp_last      = last;
        i_nresp_with_data = wd;
        acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            cycle();
            acc = last_nacc;
        end
        i_nresp_valid = 1'b0;
        chk("nresp_accepted", CW'(acc), CW'(1));
    endtask

    task automatic fill_rand(input int n);
        gn = n;
        for (int k = 0; k < n; k++) begin
            gd[k] = {$urandom, $urandom};
            ge[k] = ($urandom_range(0, 7) == 0);
            gi[k] = IDW'($urandom);
        end
    endtask

    // Beat k of a burst sits at position start+k; wide beat = position / R, lane = position % R.
    task automatic expect_burst();
        logic [WW-1:0] w;
        logic          ea;
        int            p;
        chk("info_available", CW'(info_q.size() != 0), CW'(1));
        gstart = (info_q.size() != 0) ? info_q[0] : 0;
        w  = '0;
        ea = 1'b0;
        for (int k = 0; k < gn; k++) begin
            p = (gstart + k) % R;
            w[p*NW +: NW] = gd[k];
            ea = ea | ge[k];
            if (p == R - 1 || k == gn - 1) begin
                exp_q.push_back('{data: w, id: gi[k], err: ea, last: logic'(k == gn - 1), wd: 1'b1});
                w  = '0;
                ea = 1'b0;
            end
        end
    endtask

    task automatic send_beats(input int k0, input int k1, input int gap);
        bit acc;
        for (int k = k0; k < k1; k++) begin
            repeat ($urandom_range(0, gap)) cycle();
            send_beat(gd[k], ge[k], gi[k], logic'(k == gn - 1), 1'b1, acc);
            if (acc && (((gstart + k) % R) == R - 1 || k == gn - 1))
                chk("wresp_latency", CW'(o_wresp_valid), CW'(1));
            if (acc && k == gn - 1 && info_q.size() != 0) void'(info_q.pop_front());
        end
    endtask

    task automatic send_nodata(input logic [IDW-1:0] id, input logic err, input logic last);
        bit acc;
        exp_q.push_back('{data: '0, id: id, err: err, last: last, wd: 1'b0});
        send_beat({$urandom, $urandom}, err, id, last, 1'b0, acc);
        if (acc) chk("nodata_latency", CW'(o_wresp_valid), CW'(1));
    endtask

    task automatic stall_check(input string tag);
        i_nresp_valid     = 1'b1;
        i_nresp_with_data = 1'b1;
        i_nresp_last      = 1'b0;
        i_nresp_data      = {$urandom, $urandom};
        #1;
        chk(tag, CW'(o_nresp_accept), CW'(0));
        cycle();
        chk({tag, "_held"}, CW'(last_nacc), CW'(0));
        i_nresp_valid = 1'b0;
    endtask

    initial begin
        int np;
        rst_n = 1'b1;
        i_info_valid = 1'b0; i_info_lane = '0;
        i_nresp_valid = 1'b0; i_nresp_with_data = 1'b0; i_nresp_id = '0;
        i_nresp_error = 1'b0; i_nresp_data = '0; i_nresp_last = 1'b0;
        i_wresp_accept = 1'b0;
        hold_prev = 1'b0; rnd_acc = 1'b0; last_nacc = 1'b0; saved = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", out_vec(), CW'(0));
        chk("reset_info_ready", CW'(o_info_ready), CW'(1));
        cycle();
        cycle();
        rst_n = 1'b1;
        i_wresp_accept = 1'b1;

        // Lane-0 start, four beats back to back: two full wide beats.
        push_info(0);
        fill_rand(4);
        for (int k = 0; k < 4; k++) ge[k] = 1'b0;
        expect_burst();
        send_beats(0, 4, 0);

        // Lane-1 start, three beats: half-filled first wide beat.
        push_info(1);
        fill_rand(3);
        expect_burst();
        send_beats(0, 3, 0);
        stall_check("empty_fifo_stall");

        // No-data response passes straight through, then data resumes.
        send_nodata(IDW'(5), 1'b0, 1'b1);
        push_info(1);
        fill_rand(2);
        expect_burst();
        send_beats(0, 2, 0);

        // Single-beat burst, then error on the first beat of a pair.
        push_info(0);
        fill_rand(1);
        ge[0] = 1'b0;
        expect_burst();
        send_beats(0, 1, 0);
        push_info(0);
        fill_rand(2);
        ge[0] = 1'b1;
        ge[1] = 1'b0;
        expect_burst();
        send_beats(0, 2, 0);

        // Output held by backpressure blocks the next completing beat.
        repeat (2) cycle();
        i_wresp_accept = 1'b0;
        push_info(0);
        fill_rand(4);
        expect_burst();
        send_beats(0, 3, 0);
        i_nresp_valid = 1'b1; i_nresp_with_data = 1'b1;
        i_nresp_data = gd[3]; i_nresp_error = ge[3]; i_nresp_id = gi[3]; i_nresp_last = 1'b1;
        #1;
        chk("backpressure_stall", CW'(o_nresp_accept), CW'(0));
        repeat (3) cycle();
        chk("backpressure_stall_held", CW'(last_nacc), CW'(0));
        i_wresp_accept = 1'b1;
        send_beats(3, 4, 0);

        // Fill the FIFO, push once more while full, then drain with bursts.
        repeat (2) cycle();
        push_info(0); push_info(1); push_info(1); push_info(0);
        push_info(1);
        for (int b = 0; b < 4; b++) begin
            fill_rand($urandom_range(1, 5));
            expect_burst();
            send_beats(0, gn, 1);
        end

        // Reset in the middle of a burst discards everything.
        repeat (2) cycle();
        i_wresp_accept = 1'b0;
        push_info(1);
        fill_rand(3);
        expect_burst();
        send_beats(0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", out_vec(), CW'(0));
        chk("midrst_info_ready", CW'(o_info_ready), CW'(1));
        exp_q.delete();
        info_q.delete();
        hold_prev = 1'b0;
        cycle();
        rst_n = 1'b1;
        i_wresp_accept = 1'b1;
        stall_check("post_reset_stall");
        push_info(0);
        fill_rand(2);
        expect_burst();
        send_beats(0, 2, 0);

        // Randomized bursts with random backpressure and gaps.
        rnd_acc = 1'b1;
        for (int it = 0; it < 40; it++) begin
            np = $urandom_range(1, 2);
            for (int j = 0; j < np; j++)
                if (info_q.size() < DEPTH) push_info($urandom_range(0, R - 1));
            if ($urandom_range(0, 3) == 0)
                send_nodata(IDW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fill_rand($urandom_range(1, 6));
            expect_burst();
            send_beats(0, gn, 2);
        end

        rnd_acc = 1'b0;
        i_wresp_accept = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) cycle();
        chk("drain_empty", CW'(exp_q.size()), CW'(0));
        cycle();
        chk("final_idle", CW'(o_wresp_valid), CW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pzcorebus_downsizer_response_packer.md
PZCOREBUS_DOWNSIZER_RESPONSE_PACKER -- requirements
Module: pzcorebus_downsizer_response_packer

Interface
REQ-001 SHALL have parameter NARROW_DATA_WIDTH, default 64, meaning narrow response data width in bits.
REQ-002 SHALL have parameter CONVERSION_RATIO, default 2, meaning wide/narrow width ratio (power of 2, >=2); LANE_WIDTH = clog2(CONVERSION_RATIO).
REQ-003 SHALL have parameter INFO_DEPTH, default 4, meaning entries in start-lane FIFO.
REQ-004 SHALL have parameter ID_WIDTH, default 8, meaning response ID width.
REQ-005 SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_info_valid  input  1  start-lane push request, one per read command.
REQ-008 SHALL have port o_info_ready  output  1  FIFO can accept push.
REQ-009 SHALL have port i_info_lane  input  LANE_WIDTH  wide-beat lane of the command's first narrow data beat.
REQ-010 SHALL have port i_nresp_valid  input  1  narrow response beat valid.
REQ-011 SHALL have port o_nresp_accept  output  1  narrow beat accepted this cycle when valid.
REQ-012 SHALL have port i_nresp_with_data  input  1  1 = read data response, 0 = no-data response.
REQ-013 SHALL have ports i_nresp_id (ID_WIDTH), i_nresp_error (1), i_nresp_data (NARROW_DATA_WIDTH), i_nresp_last (1)  input  narrow response fields.
REQ-014 SHALL have port o_wresp_valid  output  1  wide response beat valid.
REQ-015 SHALL have port i_wresp_accept  input  1  wide beat consumed when valid.
REQ-016 SHALL have ports o_wresp_with_data (1), o_wresp_id (ID_WIDTH), o_wresp_error (1), o_wresp_data (NARROW_DATA_WIDTH*CONVERSION_RATIO), o_wresp_last (1)  output  wide response fields.

Function
REQ-017 Info FIFO SHALL hold INFO_DEPTH lanes; o_info_ready = !full (no same-cycle bypass); push on i_info_valid && o_info_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-018 Lane counter SHALL load FIFO head lane on first data beat of a response (state IDLE -> PACK), increment by 1 per accepted data beat, wrap RATIO-1 -> 0.
REQ-019 Accepted data beat SHALL write i_nresp_data into accumulator lane = current lane; lanes not written in that wide beat SHALL be zero.
REQ-020 A data beat is "completing" when lane == RATIO-1 or i_nresp_last=1; non-completing beats SHALL be accepted unconditionally (FIFO non-empty).
REQ-021 Completing beat SHALL be accepted only when output register free (!o_wresp_valid || i_wresp_accept); on acceptance accumulator+beat loads output register, accumulator clears, lanes restart.
REQ-022 Latency: o_wresp_valid SHALL assert the cycle after the completing narrow beat is accepted; full throughput 1 wide beat/cycle.
REQ-023 o_wresp_error SHALL be OR of i_nresp_error over all narrow beats in that wide beat; o_wresp_id = id of completing beat; o_wresp_last = i_nresp_last of completing beat.
REQ-024 On accepted data beat with i_nresp_last=1, FIFO SHALL pop and state SHALL return to IDLE.
REQ-025 Data response with FIFO empty in IDLE SHALL be stalled (o_nresp_accept=0) until an entry exists.
REQ-026 No-data response SHALL bypass FIFO and accumulator, be accepted when output register free, produce one wide beat with data=0, with_data=0, fields copied; SHALL only be accepted in IDLE.
REQ-027 Output register fields SHALL hold stable while o_wresp_valid && !i_wresp_accept.
REQ-028 o_nresp_accept SHALL be 0 whenever i_nresp_valid=0 is irrelevant; it is combinational from state, FIFO empty, lane, last, output-register status.

Reset
REQ-029 Asserting i_rst_n=0 SHALL immediately clear FIFO (o_info_ready=1), state to IDLE, lane=0, accumulator=0, o_wresp_valid=0, all o_wresp_* fields 0, including mid-burst; partial data discarded.

Verification (RATIO=2, NARROW_DATA_WIDTH=64)
REQ-030 Push lane 0; data beats A,B,C,D (last on D) -> wide {B,A} last=0 then {D,C} last=1, one cycle after B and D accepted.
REQ-031 Push lane 1; beats X,Y,Z (last on Z) -> {X,0}, then {Z,Y} last=1; FIFO empty after Z.
REQ-032 Push lane 0; single beat A last=1 -> {0,A} last=1; error=1 on A only of 2-beat group -> wide error=1.
REQ-033 Hold i_wresp_accept=0 with output valid; next completing beat -> o_nresp_accept=0, output unchanged until accept=1.
REQ-034 FIFO empty, data beat valid -> accept=0; no-data response id=5 -> wide with_data=0, id=5, data=0; push lane then data proceeds.
REQ-035 Reset after beat X of REQ-031 -> o_wresp_valid=0, FIFO empty, next burst packs from fresh lane.
